// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the counter scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } sched_state_t;

  // Default count width; matches the shared counter.
  localparam int CNT_WIDTH_DEF = 7;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Scan NUM_REQ positions starting at ptr; first hit wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one counter between NUM_REQ requesters: round-robin grant, launch,
// wait for done with a watchdog, then return done/err to the owner.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter  int TIMEOUT   = 1023,
  localparam int ID_W      = id_width(NUM_REQ),
  localparam int WD_W      = $clog2(TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] cnt_val_i,
  output logic [NUM_REQ-1:0]           ack_o,
  output logic [NUM_REQ-1:0]           done_o,
  output logic [NUM_REQ-1:0]           err_o,
  output logic                         busy_o,
  output logic [ID_W-1:0]              grant_id_o,
  output logic                         ctr_start_o,
  output logic [CNT_WIDTH-1:0]         ctr_cnt_val_o,
  input  logic                         ctr_done_i
);

  sched_state_t         state;
  logic [ID_W-1:0]      ptr;
  logic [WD_W-1:0]      wd;
  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_id;
  logic [CNT_WIDTH-1:0] win_val;
  logic [NUM_REQ-1:0]   id_mask;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_i),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Candidate value of the current arbitration winner.
  always_comb begin
    win_val = cnt_val_i[int'(gnt_id)*CNT_WIDTH +: CNT_WIDTH];
  end

  // One-hot of the owner; grant_id_o doubles as the latched owner id.
  assign id_mask = NUM_REQ'(1) << grant_id_o;

  // Scheduler FSM; pulse outputs default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      wd            <= '0;
      ack_o         <= '0;
      done_o        <= '0;
      err_o         <= '0;
      busy_o        <= 1'b0;
      grant_id_o    <= '0;
      ctr_start_o   <= 1'b0;
      ctr_cnt_val_o <= '0;
    end else begin
      ack_o       <= '0;
      done_o      <= '0;
      err_o       <= '0;
      ctr_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            state         <= LAUNCH;
            busy_o        <= 1'b1;
            grant_id_o    <= gnt_id;
            ctr_cnt_val_o <= win_val;
            ack_o         <= gnt;
            // A zero-length job never touches the counter.
            ctr_start_o   <= (win_val != '0);
          end
        end
        LAUNCH: begin
          wd <= '0;
          if (ctr_cnt_val_o != '0) begin
            state <= WAIT;
          end else begin
            state  <= FINISH;
            done_o <= id_mask;
          end
        end
        WAIT: begin
          // Done takes priority over a same-cycle timeout.
          if (ctr_done_i) begin
            state  <= FINISH;
            done_o <= id_mask;
          end else if (wd == WD_W'(TIMEOUT)) begin
            state  <= FINISH;
            done_o <= id_mask;
            err_o  <= id_mask;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        FINISH: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          ptr    <= (grant_id_o == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant_id_o + 1'b1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler with a behavioural counter model.
module tb_counter_scheduler;

  logic        clk, rst;
  logic [3:0]  req_i, ack_o, done_o, err_o;
  logic [11:0] cnt_val_i;
  logic        busy_o, ctr_start_o, ctr_done_i;
  logic [1:0]  grant_id_o;
  logic [2:0]  ctr_cnt_val_o;

  counter_scheduler #(.NUM_REQ(4), .CNT_WIDTH(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .cnt_val_i(cnt_val_i),
    .ack_o(ack_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .grant_id_o(grant_id_o), .ctr_start_o(ctr_start_o),
    .ctr_cnt_val_o(ctr_cnt_val_o), .ctr_done_i(ctr_done_i)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int cyc = 0, checks = 0, errors = 0, mptr = 0, starts = 0, rem = 0;
  bit armed = 0, ctr_dead = 0, ctr_force = 0, auto_drop = 1;
  logic [2:0] vals [4];

  // Round-robin rule: first pending index at or after ptr, wrapping.
  function automatic int arb(input logic [3:0] p, input int ptr);
    for (int k = 0; k < 4; k++) if (p[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // One cycle: sample at negedge, then the counter model drives ctr_done_i.
  // The counter raises done exactly 'value' cycles after its start pulse.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (ctr_start_o) starts++;
    if (rst) armed = 0;
    else if (ctr_start_o && !ctr_dead) begin armed = 1; rem = int'(ctr_cnt_val_o); end
    else if (armed && rem > 0) rem--;
    ctr_done_i = (armed && rem == 0) || ctr_force;
    if (armed && rem == 0) armed = 0;
  endtask

  // Post a request set in IDLE, run until ack and done, return in IDLE.
  task automatic serve(input logic [3:0] rq, output int t_req, output int ack_cyc,
                       output int done_cyc, output logic [3:0] av, output logic [3:0] dv,
                       output logic [3:0] ev, output bit st, output logic [2:0] sv,
                       output int nstart, output int extra);
    int s0;
    t_req = cyc; req_i = rq; cnt_val_i = {vals[3], vals[2], vals[1], vals[0]};
    s0 = starts; ack_cyc = -1; done_cyc = -1; av = 0; dv = 0; ev = 0; st = 0; sv = 0; extra = 0;
    for (int i = 0; i < 40 && ack_cyc < 0; i++) begin
      step();
      if (|ack_o) begin
        ack_cyc = cyc; av = ack_o; st = ctr_start_o; sv = ctr_cnt_val_o;
        if (auto_drop) req_i = req_i & ~ack_o;
      end
    end
    if (ack_cyc >= 0)
      for (int i = 0; i < 60 && done_cyc < 0; i++) begin
        step();
        if (|ack_o) extra++;
        if (|done_o) begin done_cyc = cyc; dv = done_o; ev = err_o; end
      end
    step();
    nstart = starts - s0;
  endtask

  task automatic test_reset();
    rst = 1; req_i = 0; cnt_val_i = 0; ctr_done_i = 0;
    repeat (3) step();
    checks++; if (ack_o !== 4'h0) begin errors++; $display("FAIL reset_ack: got %0h expected 0", ack_o); end
    checks++; if (done_o !== 4'h0) begin errors++; $display("FAIL reset_done: got %0h expected 0", done_o); end
    checks++; if (err_o !== 4'h0) begin errors++; $display("FAIL reset_err: got %0h expected 0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
    checks++; if (grant_id_o !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d expected 0", grant_id_o); end
    checks++; if (ctr_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b expected 0", ctr_start_o); end
    checks++; if (ctr_cnt_val_o !== 3'd0) begin errors++; $display("FAIL reset_val: got %0d expected 0", ctr_cnt_val_o); end
    rst = 0;
    repeat (2) step();
    checks++; if (busy_o !== 1'b0 || ack_o !== 4'h0) begin errors++; $display("FAIL idle_quiet: busy %0b ack %0h expected 0 0", busy_o, ack_o); end
    mptr = 0;
  endtask

  task automatic test_single();
    int t, a, d, ns, ex; logic [3:0] av, dv, ev; bit st; logic [2:0] sv;
    vals[0] = 5;
    serve(4'b0001, t, a, d, av, dv, ev, st, sv, ns, ex);
    checks++; if (av !== 4'b0001) begin errors++; $display("FAIL single_ack: got %0h expected 1", av); end
    checks++; if (a != t + 1) begin errors++; $display("FAIL single_ack_time: got %0d expected %0d", a, t + 1); end
    checks++; if (st !== 1'b1 || sv !== 3'd5) begin errors++; $display("FAIL single_start: got %0b/%0d expected 1/5", st, sv); end
    checks++; if (d != a + 6) begin errors++; $display("FAIL single_done_time: got %0d expected %0d", d, a + 6); end
    checks++; if (dv !== 4'b0001 || ev !== 4'h0) begin errors++; $display("FAIL single_done: got %0h/%0h expected 1/0", dv, ev); end
    checks++; if (ns != 1) begin errors++; $display("FAIL single_nstart: got %0d expected 1", ns); end
    mptr = 1;
  endtask

  task automatic test_zero();
    int t, a, d, ns, ex; logic [3:0] av, dv, ev; bit st; logic [2:0] sv;
    vals[2] = 0;
    serve(4'b0100, t, a, d, av, dv, ev, st, sv, ns, ex);
    checks++; if (av !== 4'b0100 || a != t + 1) begin errors++; $display("FAIL zero_ack: got %0h@%0d expected 4@%0d", av, a, t + 1); end
    checks++; if (dv !== 4'b0100 || d != t + 2) begin errors++; $display("FAIL zero_done: got %0h@%0d expected 4@%0d", dv, d, t + 2); end
    checks++; if (ev !== 4'h0) begin errors++; $display("FAIL zero_err: got %0h expected 0", ev); end
    checks++; if (ns != 0) begin errors++; $display("FAIL zero_nstart: got %0d expected 0", ns); end
    mptr = 3;
  endtask

  task automatic test_priority();
    int t, a, d, ns, ex; logic [3:0] av, dv, ev; bit st; logic [2:0] sv;
    vals[1] = 2; vals[3] = 4;
    serve(4'b0010, t, a, d, av, dv, ev, st, sv, ns, ex);
    checks++; if (av !== 4'b0010) begin errors++; $display("FAIL prio_setup: got %0h expected 2", av); end
    serve(4'b1010, t, a, d, av, dv, ev, st, sv, ns, ex);
    checks++; if (av !== 4'b1000 || a != t + 1) begin errors++; $display("FAIL prio_first: got %0h@%0d expected 8@%0d", av, a, t + 1); end
    serve(req_i, t, a, d, av, dv, ev, st, sv, ns, ex);
    checks++; if (av !== 4'b0010 || a != t + 1) begin errors++; $display("FAIL prio_second: got %0h@%0d expected 2@%0d", av, a, t + 1); end
    mptr = 2;
  endtask

  task automatic test_all_held();
    int t, a, d, ns, ex, pd, e; logic [3:0] av, dv, ev, one; bit st; logic [2:0] sv;
    auto_drop = 0; pd = -1; one = 4'b0001;
    for (int k = 0; k < 4; k++) vals[k] = 3'($urandom_range(1, 7));
    for (int j = 0; j < 8; j++) begin
      e = arb(4'b1111, mptr);
      serve(4'b1111, t, a, d, av, dv, ev, st, sv, ns, ex);
      checks++; if (av !== (one << e)) begin errors++; $display("FAIL held_order%0d: got %0h expected %0h", j, av, one << e); end
      checks++; if (a != ((j == 0) ? t + 1 : pd + 2)) begin errors++; $display("FAIL held_ack_time%0d: got %0d expected %0d", j, a, (j == 0) ? t + 1 : pd + 2); end
      checks++; if (d != a + int'(vals[e]) + 1 || dv !== av || ev !== 4'h0) begin errors++; $display("FAIL held_done%0d: got %0h/%0h@%0d expected %0h/0@%0d", j, dv, ev, d, av, a + int'(vals[e]) + 1); end
      checks++; if (ex != 0 || ns != 1) begin errors++; $display("FAIL held_overlap%0d: extra acks %0d starts %0d expected 0 1", j, ex, ns); end
      pd = d; mptr = (e + 1) % 4;
    end
    req_i = 0; auto_drop = 1;
  endtask

  task automatic test_timeout();
    int t, a, d, ns, ex; logic [3:0] av, dv, ev; bit st; logic [2:0] sv;
    ctr_dead = 1; vals[0] = 3;
    serve(4'b0001, t, a, d, av, dv, ev, st, sv, ns, ex);
    checks++; if (av !== 4'b0001 || ns != 1) begin errors++; $display("FAIL to_ack: got %0h starts %0d expected 1 1", av, ns); end
    checks++; if (d != a + 18) begin errors++; $display("FAIL to_time: got %0d expected %0d", d, a + 18); end
    checks++; if (dv !== 4'b0001 || ev !== 4'b0001) begin errors++; $display("FAIL to_flags: got %0h/%0h expected 1/1", dv, ev); end
    ctr_dead = 0; vals[2] = 2;
    serve(4'b0100, t, a, d, av, dv, ev, st, sv, ns, ex);
    checks++; if (av !== 4'b0100 || d != a + 3 || ev !== 4'h0) begin errors++; $display("FAIL to_recover: got %0h@%0d err %0h expected 4@%0d err 0", av, d, ev, a + 3); end
    mptr = 3;
  endtask

  task automatic test_reset_mid();
    int t, a, d, ns, ex; bit seen; logic [3:0] av, dv, ev; bit st; logic [2:0] sv;
    ctr_dead = 1; vals[2] = 3;
    req_i = 4'b0100; cnt_val_i = {vals[3], vals[2], vals[1], vals[0]};
    step();
    checks++; if (ack_o !== 4'b0100) begin errors++; $display("FAIL rm_ack: got %0h expected 4", ack_o); end
    req_i = 0;
    repeat (3) step();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rm_wait: busy %0b expected 1", busy_o); end
    rst = 1;
    step();
    checks++; if ({ack_o, done_o, err_o, busy_o, grant_id_o, ctr_start_o, ctr_cnt_val_o} !== '0) begin errors++; $display("FAIL rm_clear: got %0h expected 0", {ack_o, done_o, err_o, busy_o, grant_id_o, ctr_start_o, ctr_cnt_val_o}); end
    rst = 0; ctr_dead = 0; ctr_force = 1;
    step();
    ctr_force = 0; seen = (|done_o) || busy_o || (|err_o);
    repeat (4) begin step(); if ((|done_o) || busy_o || (|err_o)) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_stale_done: activity %0b expected 0", seen); end
    mptr = 0; vals[1] = 1; vals[3] = 1;
    serve(4'b1010, t, a, d, av, dv, ev, st, sv, ns, ex);
    checks++; if (av !== 4'b0010) begin errors++; $display("FAIL rm_ptr: got %0h expected 2", av); end
    serve(req_i, t, a, d, av, dv, ev, st, sv, ns, ex);
    checks++; if (av !== 4'b1000) begin errors++; $display("FAIL rm_next: got %0h expected 8", av); end
    mptr = 0;
  endtask

  task automatic test_random();
    int t, a, d, ns, ex, e, ed; logic [3:0] av, dv, ev, pend, one; bit st; logic [2:0] sv;
    pend = 0; one = 4'b0001;
    for (int j = 0; j < 40; j++) begin
      for (int k = 0; k < 4; k++)
        if (!pend[k] && $urandom_range(0, 2) == 0) begin pend[k] = 1; vals[k] = 3'($urandom_range(0, 7)); end
      if ($urandom_range(0, 4) == 0) pend[$urandom_range(0, 3)] = 1'b0;
      if (pend == 0) begin
        req_i = 0;
        step();
        checks++; if (ack_o !== 4'h0 || busy_o !== 1'b0) begin errors++; $display("FAIL rnd_idle%0d: ack %0h busy %0b expected 0 0", j, ack_o, busy_o); end
        continue;
      end
      e = arb(pend, mptr);
      serve(pend, t, a, d, av, dv, ev, st, sv, ns, ex);
      ed = (vals[e] == 0) ? a + 1 : a + int'(vals[e]) + 1;
      checks++; if (av !== (one << e) || a != t + 1) begin errors++; $display("FAIL rnd_ack%0d: got %0h@%0d expected %0h@%0d", j, av, a, one << e, t + 1); end
      checks++; if (d != ed || dv !== av || ev !== 4'h0) begin errors++; $display("FAIL rnd_done%0d: got %0h/%0h@%0d expected %0h/0@%0d", j, dv, ev, d, av, ed); end
      checks++; if (ns != ((vals[e] != 0) ? 1 : 0)) begin errors++; $display("FAIL rnd_start%0d: got %0d starts for value %0d", j, ns, vals[e]); end
      pend[e] = 1'b0; mptr = (e + 1) % 4;
    end
    req_i = 0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) vals[k] = 0;
    test_reset();
    test_single();
    test_zero();
    test_priority();
    test_all_held();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench time limit expired");
  end

endmodule
